// File: rtl/axi_txn_throttle.sv
// AXI outstanding-transaction throttle: caps in-flight read/write bursts, keeps W behind AW, supports drain.
// Optional stall statistics counter enabled by `define AXI_TXN_THROTTLE_STATS_EN.
module axi_txn_throttle #(
    parameter int unsigned MAX_READ_TXNS  = 10,
    parameter int unsigned MAX_WRITE_TXNS = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slv_aw_valid_i,
    output logic        slv_aw_ready_o,
    output logic        mst_aw_valid_o,
    input  logic        mst_aw_ready_i,
    input  logic        slv_ar_valid_i,
    output logic        slv_ar_ready_o,
    output logic        mst_ar_valid_o,
    input  logic        mst_ar_ready_i,
    input  logic        slv_w_valid_i,
    input  logic        slv_w_last_i,
    output logic        slv_w_ready_o,
    output logic        mst_w_valid_o,
    input  logic        mst_w_ready_i,
    input  logic        b_valid_i,
    input  logic        b_ready_i,
    input  logic        r_valid_i,
    input  logic        r_ready_i,
    input  logic        r_last_i,
    input  logic        drain_i,
    output logic        drained_o,
    output logic [7:0]  rd_cnt_o,
    output logic [7:0]  wr_cnt_o,
    output logic        err_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(MAX_READ_TXNS);
    localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(MAX_WRITE_TXNS);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAINING = 2'd1,
        DRAINED  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] w_credit;

    logic aw_allow, ar_allow, w_allow;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

    // Allows depend only on registered state; reset forces them low.
    assign aw_allow = ~rst_i & (state == RUN) & (wr_cnt < WR_MAX);
    assign ar_allow = ~rst_i & (state == RUN) & (rd_cnt < RD_MAX);
    assign w_allow  = ~rst_i & (w_credit != '0);

    assign mst_aw_valid_o = slv_aw_valid_i & aw_allow;
    assign slv_aw_ready_o = mst_aw_ready_i & aw_allow;
    assign mst_ar_valid_o = slv_ar_valid_i & ar_allow;
    assign slv_ar_ready_o = mst_ar_ready_i & ar_allow;
    assign mst_w_valid_o  = slv_w_valid_i & w_allow;
    assign slv_w_ready_o  = mst_w_ready_i & w_allow;

    assign aw_hs     = slv_aw_valid_i & mst_aw_ready_i & aw_allow;
    assign ar_hs     = slv_ar_valid_i & mst_ar_ready_i & ar_allow;
    assign w_last_hs = slv_w_valid_i & mst_w_ready_i & w_allow & slv_w_last_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

    assign rd_cnt_o = rd_cnt;
    assign wr_cnt_o = wr_cnt;

    // Outstanding counters; a decrement of an empty counter holds at zero and flags an error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            w_credit <= '0;
            err_o    <= 1'b0;
        end else begin
            unique case ({aw_hs, b_hs})
                2'b10:   wr_cnt <= wr_cnt + CNT_W'(1);
                2'b01:   if (wr_cnt == '0) err_o <= 1'b1; else wr_cnt <= wr_cnt - CNT_W'(1);
                default: wr_cnt <= wr_cnt;
            endcase
            unique case ({ar_hs, r_last_hs})
                2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
                2'b01:   if (rd_cnt == '0) err_o <= 1'b1; else rd_cnt <= rd_cnt - CNT_W'(1);
                default: rd_cnt <= rd_cnt;
            endcase
            unique case ({aw_hs, w_last_hs})
                2'b10:   if (w_credit != '1) w_credit <= w_credit + CNT_W'(1);
                2'b01:   if (w_credit == '0) err_o <= 1'b1; else w_credit <= w_credit - CNT_W'(1);
                default: w_credit <= w_credit;
            endcase
        end
    end

    // Drain sequencing; drained_o tracks entry into and exit from DRAINED.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            drained_o <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (drain_i) state <= DRAINING;
                end
                DRAINING: begin
                    if (!drain_i) begin
                        state <= RUN;
                    end else if (rd_cnt == '0 && wr_cnt == '0 && w_credit == '0) begin
                        state     <= DRAINED;
                        drained_o <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_i) begin
                        state     <= RUN;
                        drained_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    drained_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_TXN_THROTTLE_STATS_EN
    logic        stall;
    logic [31:0] stall_cnt;

    assign stall = (slv_aw_valid_i & ~aw_allow) | (slv_ar_valid_i & ~ar_allow);

    // Saturating count of cycles with a blocked AW or AR request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_txn_throttle.sv
// Directed self-checking bench for axi_txn_throttle with default parameters.
module tb_axi_txn_throttle;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
    logic        slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
    logic        slv_w_valid_i, slv_w_last_i, slv_w_ready_o, mst_w_valid_o, mst_w_ready_i;
    logic        b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
    logic        drain_i, drained_o, err_o;
    logic [7:0]  rd_cnt_o, wr_cnt_o;
    logic [31:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    axi_txn_throttle dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .mst_aw_valid_o (mst_aw_valid_o),
        .mst_aw_ready_i (mst_aw_ready_i),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .slv_w_valid_i  (slv_w_valid_i),
        .slv_w_last_i   (slv_w_last_i),
        .slv_w_ready_o  (slv_w_ready_o),
        .mst_w_valid_o  (mst_w_valid_o),
        .mst_w_ready_i  (mst_w_ready_i),
        .b_valid_i      (b_valid_i),
        .b_ready_i      (b_ready_i),
        .r_valid_i      (r_valid_i),
        .r_ready_i      (r_ready_i),
        .r_last_i       (r_last_i),
        .drain_i        (drain_i),
        .drained_o      (drained_o),
        .rd_cnt_o       (rd_cnt_o),
        .wr_cnt_o       (wr_cnt_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        slv_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0;
        slv_w_valid_i  = 1'b0; slv_w_last_i   = 1'b0; mst_w_ready_i = 1'b0;
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        drain_i   = 1'b0;
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset behaviour, including allow held low while reset is asserted
        idle();
        rst_i = 1'b1;
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        #1;
        chk("aw_blocked_in_reset", 32'(mst_aw_valid_o), 32'd0);
        step();
        step();
        chk("rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_drained", 32'(drained_o), 32'd0);
        chk("rst_stall", stall_cnt_o, 32'd0);
        do_reset();

        // Write limit: 12 accepted, 13th stalls, one B frees a slot next cycle
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("aw_fill_ready", 32'(slv_aw_ready_o), 32'd1);
            step();
        end
        chk("aw_full_cnt", 32'(wr_cnt_o), 32'd12);
        chk("aw_full_ready", 32'(slv_aw_ready_o), 32'd0);
        chk("aw_full_valid", 32'(mst_aw_valid_o), 32'd0);
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        #1;
        chk("aw_blocked_during_b", 32'(slv_aw_ready_o), 32'd0);
        step();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        chk("wr_cnt_after_b", 32'(wr_cnt_o), 32'd11);
        chk("aw_ready_after_b", 32'(slv_aw_ready_o), 32'd1);
        step();
        chk("wr_cnt_refill", 32'(wr_cnt_o), 32'd12);
        do_reset();

        // Read limit with simultaneous AR and R last at full count
        slv_ar_valid_i = 1'b1; mst_ar_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("rd_full_cnt", 32'(rd_cnt_o), 32'd10);
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b1;
        #1;
        chk("ar_blocked_full", 32'(slv_ar_ready_o), 32'd0);
        step();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("rd_cnt_after_r", 32'(rd_cnt_o), 32'd9);
        chk("ar_ready_after_r", 32'(slv_ar_ready_o), 32'd1);
        step();
        chk("rd_cnt_refill", 32'(rd_cnt_o), 32'd10);
        slv_ar_valid_i = 1'b0;
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b1;
        step();
        chk("rd_cnt_r_only", 32'(rd_cnt_o), 32'd9);
        slv_ar_valid_i = 1'b1;
        step();
        chk("rd_cnt_ar_and_r", 32'(rd_cnt_o), 32'd9);
        do_reset();

        // W must not lead AW; a 4-beat burst consumes exactly one credit
        slv_w_valid_i = 1'b1; mst_w_ready_i = 1'b1;
        #1;
        chk("w_no_credit_valid", 32'(mst_w_valid_o), 32'd0);
        chk("w_no_credit_ready", 32'(slv_w_ready_o), 32'd0);
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        #1;
        chk("w_blocked_same_cycle_aw", 32'(mst_w_valid_o), 32'd0);
        step();
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slv_w_last_i = (i == 3);
            #1;
            chk("w_beat_pass", 32'(mst_w_valid_o), 32'd1);
            step();
        end
        chk("w_after_last", 32'(mst_w_valid_o), 32'd0);
        chk("w_wr_cnt", 32'(wr_cnt_o), 32'd1);
        chk("w_no_err", 32'(err_o), 32'd0);
        do_reset();

        // Drain with 3 reads and 2 writes outstanding
        slv_ar_valid_i = 1'b1; mst_ar_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        idle();
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) step();
        idle();
        chk("pre_drain_rd", 32'(rd_cnt_o), 32'd3);
        chk("pre_drain_wr", 32'(wr_cnt_o), 32'd2);
        drain_i = 1'b1;
        step();
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        slv_ar_valid_i = 1'b1; mst_ar_ready_i = 1'b1;
        #1;
        chk("drain_aw_blocked", 32'(slv_aw_ready_o), 32'd0);
        chk("drain_ar_blocked", 32'(slv_ar_ready_o), 32'd0);
        chk("drain_not_done", 32'(drained_o), 32'd0);
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        slv_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0;
        slv_w_valid_i = 1'b1; mst_w_ready_i = 1'b1; slv_w_last_i = 1'b1;
        #1;
        chk("drain_w_allowed", 32'(slv_w_ready_o), 32'd1);
        for (int i = 0; i < 2; i++) step();
        slv_w_valid_i = 1'b0; mst_w_ready_i = 1'b0; slv_w_last_i = 1'b0;
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) step();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        chk("drain_rd_zero", 32'(rd_cnt_o), 32'd0);
        chk("drain_wr_zero", 32'(wr_cnt_o), 32'd0);
        chk("drain_one_cycle_late", 32'(drained_o), 32'd0);
        step();
        chk("drained", 32'(drained_o), 32'd1);
        chk("drain_err_clean", 32'(err_o), 32'd0);
        drain_i = 1'b0;
        step();
        chk("undrained", 32'(drained_o), 32'd0);
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        #1;
        chk("run_aw_ready", 32'(slv_aw_ready_o), 32'd1);
        do_reset();

        // Underflow error is sticky until reset
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        step();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        chk("err_set", 32'(err_o), 32'd1);
        chk("err_wr_cnt", 32'(wr_cnt_o), 32'd0);
        step();
        chk("err_sticky", 32'(err_o), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err_o), 32'd0);

        // Stall counting with AR held while reads are full
        slv_ar_valid_i = 1'b1; mst_ar_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 5; i++) step();
`ifdef AXI_TXN_THROTTLE_STATS_EN
        chk("stall_cnt", stall_cnt_o, 32'd5);
`else
        chk("stall_cnt", stall_cnt_o, 32'd0);
`endif
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
